// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts register-to-register commands, drives an external ALU and returns its result.
//   Ports: clk/rst (async active-high); cmd_valid/cmd_ready/cmd_op/cmd_src_a/cmd_src_b/cmd_dst command handshake;
//   wr_en/wr_addr/wr_data external register-file write; alu_a/alu_b/alu_op to ALU, alu_result/alu_overflow from ALU;
//   rsp_valid/rsp_ready/rsp_result/rsp_overflow response handshake; ovf_sticky/ovf_clr overflow poll flag.
module alu_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_src_a,
    input  logic [AW-1:0]    cmd_src_b,
    input  logic [AW-1:0]    cmd_dst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [AW-1:0]    r_dst;
    logic [WIDTH-1:0] r_alu_a, r_alu_b, r_rsp_result;
    logic [2:0]       r_alu_op;
    logic             r_rsp_ovf, r_ovf_sticky;
    logic             w_accept, w_exec, w_done, w_arith;
    assign w_accept = cmd_valid && r_state == S_IDLE;
    assign w_exec   = r_state == S_EXEC;
    assign w_done   = r_state == S_RESP && rsp_ready;
    // Only add/sub/shl/shr carry a meaningful overflow; logic ops and rotate are masked.
    assign w_arith  = r_alu_op inside {3'b000, 3'b001, 3'b101, 3'b110};
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_EXEC : S_IDLE;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  w_next = rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end
    always_comb begin
        cmd_ready = r_state == S_IDLE;
        rsp_valid = r_state == S_RESP;
    end
    // Write-back from EXEC takes precedence over an external write to the same entry.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (w_exec && r_dst == AW'(i)) r_regs[i] <= alu_result;
                else if (wr_en && wr_addr == AW'(i)) r_regs[i] <= wr_data;
        end
    // Operands are snapshot at accept, so later register writes cannot disturb the in-flight op.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_dst    <= '0;
        end else if (w_accept) begin
            r_alu_a  <= r_regs[cmd_src_a];
            r_alu_b  <= r_regs[cmd_src_b];
            r_alu_op <= cmd_op;
            r_dst    <= cmd_dst;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_rsp_result <= '0;
            r_rsp_ovf    <= 1'b0;
        end else if (w_exec) begin
            r_rsp_result <= alu_result;
            r_rsp_ovf    <= w_arith & alu_overflow;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst)          r_ovf_sticky <= 1'b0;
        else if (ovf_clr) r_ovf_sticky <= 1'b0;
        else if (w_done)  r_ovf_sticky <= r_ovf_sticky | r_rsp_ovf;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_ovf;
    assign ovf_sticky   = r_ovf_sticky;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed self-checking bench with a behavioural 4-bit ALU model.
module tb_alu_cmd_sequencer;
    logic       clk = 0, rst = 1;
    logic       cmd_valid = 0, cmd_ready;
    logic [2:0] cmd_op = 0;
    logic [1:0] cmd_src_a = 0, cmd_src_b = 0, cmd_dst = 0;
    logic       wr_en = 0;
    logic [1:0] wr_addr = 0;
    logic [3:0] wr_data = 0;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_overflow;
    logic       rsp_valid, rsp_ready = 0, rsp_overflow, ovf_sticky, ovf_clr = 0;
    logic [3:0] rsp_result;
    int passed = 0, total = 0;
    logic [3:0] rd;
    alu_cmd_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );
    always #5 clk = ~clk;
    // ALU model: add flags carry, sub flags borrow, shl flags the bit shifted out;
    // logic ops and rotl raise overflow so the sequencer's masking is exercised.
    always_comb begin
        alu_result   = 4'd0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'd0: {alu_overflow, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: begin alu_result = alu_a - alu_b; alu_overflow = alu_a < alu_b; end
            3'd2: begin alu_result = alu_a & alu_b; alu_overflow = 1'b1; end
            3'd3: begin alu_result = alu_a | alu_b; alu_overflow = 1'b1; end
            3'd4: begin alu_result = alu_a ^ alu_b; alu_overflow = 1'b1; end
            3'd5: begin alu_result = {alu_a[2:0], 1'b0}; alu_overflow = alu_a[3]; end
            3'd6: begin alu_result = {1'b0, alu_a[3:1]}; alu_overflow = 1'b0; end
            default: begin alu_result = {alu_a[2:0], alu_a[3]}; alu_overflow = 1'b1; end
        endcase
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr_reg(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask
    task automatic issue(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] d);
        cmd_valid = 1; cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d;
        tick();
        cmd_valid = 0;
    endtask
    task automatic handshake();
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask
    task automatic read_reg(input logic [1:0] a, output logic [3:0] v);
        issue(3'd3, a, a, a);
        tick();
        v = rsp_result;
        handshake();
    endtask
    task automatic test_reset();
        tick();
        total++; if (rsp_valid !== 1'b0 || rsp_result !== 4'd0 || rsp_overflow !== 1'b0) $display("FAIL reset_rsp valid=%b result=%h ovf=%b required 0/0/0", rsp_valid, rsp_result, rsp_overflow); else passed++;
        total++; if (alu_a !== 4'd0 || alu_b !== 4'd0 || alu_op !== 3'd0 || ovf_sticky !== 1'b0) $display("FAIL reset_alu a=%h b=%h op=%h sticky=%b required all 0", alu_a, alu_b, alu_op, ovf_sticky); else passed++;
        rst = 0;
        tick();
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b required 1", cmd_ready); else passed++;
        read_reg(2'd1, rd);
        total++; if (rd !== 4'd0) $display("FAIL reset_regs r1=%h required 0", rd); else passed++;
    endtask
    task automatic test_basic_add();
        wr_reg(2'd0, 4'b0101);
        wr_reg(2'd1, 4'b0011);
        issue(3'd0, 2'd0, 2'd1, 2'd2);
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || alu_a !== 4'd5 || alu_b !== 4'd3) $display("FAIL add_exec valid=%b ready=%b a=%h b=%h required 0/0/5/3", rsp_valid, cmd_ready, alu_a, alu_b); else passed++;
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_result !== 4'b1000 || rsp_overflow !== 1'b0) $display("FAIL add_rsp valid=%b result=%h ovf=%b required 1/8/0", rsp_valid, rsp_result, rsp_overflow); else passed++;
        handshake();
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL add_done valid=%b ready=%b required 0/1", rsp_valid, cmd_ready); else passed++;
        read_reg(2'd2, rd);
        total++; if (rd !== 4'b1000) $display("FAIL add_writeback r2=%h required 8", rd); else passed++;
    endtask
    task automatic test_op_sweep();
        logic [3:0] exp [8] = '{4'b1000, 4'b0010, 4'b0001, 4'b0111, 4'b0110, 4'b1010, 4'b0010, 4'b1010};
        for (int k = 0; k < 8; k++) begin
            issue(3'(k), 2'd0, 2'd1, 2'd3);
            tick();
            total++; if (rsp_result !== exp[k] || rsp_overflow !== 1'b0) $display("FAIL sweep_op%0d result=%h ovf=%b required %h/0", k, rsp_result, rsp_overflow, exp[k]); else passed++;
            handshake();
        end
        total++; if (ovf_sticky !== 1'b0) $display("FAIL sweep_sticky got %b required 0", ovf_sticky); else passed++;
    endtask
    task automatic test_backpressure();
        issue(3'd0, 2'd0, 2'd1, 2'd3);
        tick();
        cmd_valid = 1; cmd_op = 3'd1; cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd3;
        for (int k = 0; k < 5; k++) begin
            total++; if (rsp_valid !== 1'b1 || rsp_result !== 4'd8 || cmd_ready !== 1'b0 || alu_op !== 3'd0) $display("FAIL bp_hold%0d valid=%b result=%h ready=%b op=%h required 1/8/0/0", k, rsp_valid, rsp_result, cmd_ready, alu_op); else passed++;
            tick();
        end
        handshake();
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_op !== 3'd0) $display("FAIL bp_release valid=%b ready=%b op=%h required 0/1/0", rsp_valid, cmd_ready, alu_op); else passed++;
        tick();
        cmd_valid = 0;
        total++; if (cmd_ready !== 1'b0 || alu_op !== 3'd1) $display("FAIL bp_next_accept ready=%b op=%h required 0/1", cmd_ready, alu_op); else passed++;
        tick();
        total++; if (rsp_result !== 4'd2) $display("FAIL bp_next_result got %h required 2", rsp_result); else passed++;
        handshake();
    endtask
    task automatic test_overflow();
        wr_reg(2'd2, 4'hF);
        wr_reg(2'd3, 4'h1);
        issue(3'd0, 2'd2, 2'd3, 2'd2);
        tick();
        total++; if (rsp_result !== 4'd0 || rsp_overflow !== 1'b1 || ovf_sticky !== 1'b0) $display("FAIL ovf_add result=%h ovf=%b sticky=%b required 0/1/0", rsp_result, rsp_overflow, ovf_sticky); else passed++;
        handshake();
        total++; if (ovf_sticky !== 1'b1) $display("FAIL ovf_sticky_set got %b required 1", ovf_sticky); else passed++;
        ovf_clr = 1; tick(); ovf_clr = 0;
        total++; if (ovf_sticky !== 1'b0) $display("FAIL ovf_clr got %b required 0", ovf_sticky); else passed++;
        wr_reg(2'd2, 4'hF);
        issue(3'd2, 2'd2, 2'd3, 2'd2);
        tick();
        total++; if (rsp_result !== 4'd1 || rsp_overflow !== 1'b0) $display("FAIL ovf_and_masked result=%h ovf=%b required 1/0", rsp_result, rsp_overflow); else passed++;
        handshake();
        total++; if (ovf_sticky !== 1'b0) $display("FAIL ovf_and_sticky got %b required 0", ovf_sticky); else passed++;
        wr_reg(2'd2, 4'hF);
        issue(3'd0, 2'd2, 2'd3, 2'd2);
        tick();
        ovf_clr = 1;
        handshake();
        ovf_clr = 0;
        total++; if (ovf_sticky !== 1'b0) $display("FAIL ovf_clr_priority got %b required 0", ovf_sticky); else passed++;
    endtask
    task automatic test_hazards();
        wr_reg(2'd0, 4'd5);
        wr_reg(2'd1, 4'd3);
        issue(3'd0, 2'd0, 2'd1, 2'd2);
        wr_reg(2'd2, 4'd9);
        handshake();
        read_reg(2'd2, rd);
        total++; if (rd !== 4'd8) $display("FAIL haz_wb_wins r2=%h required 8", rd); else passed++;
        issue(3'd0, 2'd0, 2'd1, 2'd2);
        wr_reg(2'd0, 4'd1);
        total++; if (rsp_result !== 4'd8) $display("FAIL haz_snapshot result=%h required 8", rsp_result); else passed++;
        handshake();
        read_reg(2'd0, rd);
        total++; if (rd !== 4'd1) $display("FAIL haz_both_writes r0=%h required 1", rd); else passed++;
        wr_en = 1; wr_addr = 2'd0; wr_data = 4'd7;
        issue(3'd0, 2'd0, 2'd1, 2'd2);
        wr_en = 0;
        tick();
        total++; if (rsp_result !== 4'd4) $display("FAIL haz_no_bypass result=%h required 4", rsp_result); else passed++;
        handshake();
        read_reg(2'd0, rd);
        total++; if (rd !== 4'd7) $display("FAIL haz_accept_write r0=%h required 7", rd); else passed++;
    endtask
    task automatic test_reset_midop();
        wr_reg(2'd0, 4'd5);
        wr_reg(2'd2, 4'd0);
        issue(3'd0, 2'd0, 2'd1, 2'd2);
        #2 rst = 1;
        #1;
        total++; if (rsp_valid !== 1'b0 || alu_a !== 4'd0 || alu_b !== 4'd0 || cmd_ready !== 1'b1) $display("FAIL rst_mid_immediate valid=%b a=%h b=%h ready=%b required 0/0/0/1", rsp_valid, alu_a, alu_b, cmd_ready); else passed++;
        tick();
        rst = 0;
        tick();
        total++; if (rsp_valid !== 1'b0 || rsp_result !== 4'd0) $display("FAIL rst_mid_no_rsp valid=%b result=%h required 0/0", rsp_valid, rsp_result); else passed++;
        read_reg(2'd2, rd);
        total++; if (rd !== 4'd0) $display("FAIL rst_mid_dst r2=%h required 0", rd); else passed++;
    endtask
    initial begin
        test_reset();
        test_basic_add();
        test_op_sweep();
        test_backpressure();
        test_overflow();
        test_hazards();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
